// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: field widths, opcode constants and A/D payload structs.
package tl_pkg;

    localparam int unsigned OPCODE_W = 3;
    localparam int unsigned SIZE_W   = 4;
    localparam int unsigned SOURCE_W = 15;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned MASK_W   = 16;
    localparam int unsigned DATA_W   = 128;
    localparam int unsigned OUTST_W  = 7;

    localparam logic [OPCODE_W-1:0] TL_GET             = 3'd4;
    localparam logic [OPCODE_W-1:0] TL_PUT_FULL        = 3'd0;
    localparam logic [OPCODE_W-1:0] TL_PUT_PARTIAL     = 3'd1;
    localparam logic [OPCODE_W-1:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [OPCODE_W-1:0] TL_ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]   address;
        logic [MASK_W-1:0]   mask;
        logic [DATA_W-1:0]   data;
    } tl_a_t;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [DATA_W-1:0]   data;
    } tl_d_t;

    localparam int unsigned A_W = $bits(tl_a_t);
    localparam int unsigned D_W = $bits(tl_d_t);

endpackage

// File: rtl/tl_fifo.sv
// Synchronous FIFO with a registered push_ready (no combinational path from pop_ready).
module tl_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push       = push_valid & ready_q;
    assign pop        = (count != '0) & pop_ready;
    assign push_ready = ready_q;
    assign pop_valid  = (count != '0);
    assign empty      = (count == '0);
    assign pop_data   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // ready is held low through reset and rises on the first edge after release
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else begin
            count   <= count_next;
            ready_q <= (count_next != FULL_CNT);
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/tl_mem_bridge.sv
// TileLink-UL bridge: buffers A requests and D responses and caps in-flight requests.
module tl_mem_bridge
    import tl_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned RSP_DEPTH       = 4
) (
    input  logic                clock,
    input  logic                reset_n,

    input  logic                in_a_valid,
    output logic                in_a_ready,
    input  logic [OPCODE_W-1:0] in_a_opcode,
    input  logic [SIZE_W-1:0]   in_a_size,
    input  logic [SOURCE_W-1:0] in_a_source,
    input  logic [ADDR_W-1:0]   in_a_address,
    input  logic [MASK_W-1:0]   in_a_mask,
    input  logic [DATA_W-1:0]   in_a_data,

    output logic                out_a_valid,
    input  logic                out_a_ready,
    output logic [OPCODE_W-1:0] out_a_opcode,
    output logic [SIZE_W-1:0]   out_a_size,
    output logic [SOURCE_W-1:0] out_a_source,
    output logic [ADDR_W-1:0]   out_a_address,
    output logic [MASK_W-1:0]   out_a_mask,
    output logic [DATA_W-1:0]   out_a_data,

    input  logic                out_d_valid,
    output logic                out_d_ready,
    input  logic [OPCODE_W-1:0] out_d_opcode,
    input  logic [SIZE_W-1:0]   out_d_size,
    input  logic [SOURCE_W-1:0] out_d_source,
    input  logic [DATA_W-1:0]   out_d_data,

    output logic                in_d_valid,
    input  logic                in_d_ready,
    output logic [OPCODE_W-1:0] in_d_opcode,
    output logic [SIZE_W-1:0]   in_d_size,
    output logic [SOURCE_W-1:0] in_d_source,
    output logic [DATA_W-1:0]   in_d_data,

    output logic [OUTST_W-1:0]  outstanding,
    output logic                idle,
    output logic                err_underflow
);

    localparam logic [OUTST_W-1:0] MAX_CNT = OUTST_W'(MAX_OUTSTANDING);

    tl_a_t              a_in;
    tl_a_t              a_head;
    tl_d_t              d_in;
    tl_d_t              d_head;
    logic               a_nonempty;
    logic               a_empty;
    logic               d_empty;
    logic               below_cap;
    logic               a_fire;
    logic               d_fire;
    logic [OUTST_W-1:0] outstanding_q;
    logic               err_q;

    assign a_in = '{opcode: in_a_opcode, size: in_a_size, source: in_a_source,
                    address: in_a_address, mask: in_a_mask, data: in_a_data};
    assign d_in = '{opcode: out_d_opcode, size: out_d_size, source: out_d_source,
                    data: out_d_data};

    tl_fifo #(.WIDTH(A_W), .DEPTH(2)) u_a_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_valid (in_a_valid),
        .push_ready (in_a_ready),
        .push_data  (a_in),
        .pop_valid  (a_nonempty),
        .pop_ready  (out_a_ready & below_cap),
        .pop_data   (a_head),
        .empty      (a_empty)
    );

    tl_fifo #(.WIDTH(D_W), .DEPTH(RSP_DEPTH)) u_d_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_valid (out_d_valid),
        .push_ready (out_d_ready),
        .push_data  (d_in),
        .pop_valid  (in_d_valid),
        .pop_ready  (in_d_ready),
        .pop_data   (d_head),
        .empty      (d_empty)
    );

    // Requests stop issuing while the in-flight cap is reached; A and D are otherwise independent
    assign below_cap   = (outstanding_q < MAX_CNT);
    assign out_a_valid = a_nonempty & below_cap;
    assign a_fire      = out_a_valid & out_a_ready;
    assign d_fire      = out_d_valid & out_d_ready;

    assign out_a_opcode  = a_head.opcode;
    assign out_a_size    = a_head.size;
    assign out_a_source  = a_head.source;
    assign out_a_address = a_head.address;
    assign out_a_mask    = a_head.mask;
    assign out_a_data    = a_head.data;

    assign in_d_opcode = d_head.opcode;
    assign in_d_size   = d_head.size;
    assign in_d_source = d_head.source;
    assign in_d_data   = d_head.data;

    // A D beat with nothing in flight is still forwarded but flagged and never wraps the count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else if (a_fire && !d_fire) begin
            outstanding_q <= outstanding_q + OUTST_W'(1);
        end else if (d_fire && !a_fire) begin
            if (outstanding_q == '0) begin
                err_q <= 1'b1;
            end else begin
                outstanding_q <= outstanding_q - OUTST_W'(1);
            end
        end
    end

    assign outstanding   = outstanding_q;
    assign err_underflow = err_q;
    assign idle          = (outstanding_q == '0) & a_empty & d_empty;

endmodule

// File: tb/tb_tl_mem_bridge.sv
// Scoreboard bench for tl_mem_bridge: stimulus pushes expected beats, negedge monitors pop and compare.
module tb_tl_mem_bridge;
    import tl_pkg::*;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                in_a_valid = 1'b0;
    logic                in_a_ready;
    logic [OPCODE_W-1:0] in_a_opcode = '0;
    logic [SIZE_W-1:0]   in_a_size = '0;
    logic [SOURCE_W-1:0] in_a_source = '0;
    logic [ADDR_W-1:0]   in_a_address = '0;
    logic [MASK_W-1:0]   in_a_mask = '0;
    logic [DATA_W-1:0]   in_a_data = '0;
    logic                out_a_valid;
    logic                out_a_ready = 1'b1;
    logic [OPCODE_W-1:0] out_a_opcode;
    logic [SIZE_W-1:0]   out_a_size;
    logic [SOURCE_W-1:0] out_a_source;
    logic [ADDR_W-1:0]   out_a_address;
    logic [MASK_W-1:0]   out_a_mask;
    logic [DATA_W-1:0]   out_a_data;
    logic                out_d_valid = 1'b0;
    logic                out_d_ready;
    logic [OPCODE_W-1:0] out_d_opcode = '0;
    logic [SIZE_W-1:0]   out_d_size = '0;
    logic [SOURCE_W-1:0] out_d_source = '0;
    logic [DATA_W-1:0]   out_d_data = '0;
    logic                in_d_valid;
    logic                in_d_ready = 1'b1;
    logic [OPCODE_W-1:0] in_d_opcode;
    logic [SIZE_W-1:0]   in_d_size;
    logic [SOURCE_W-1:0] in_d_source;
    logic [DATA_W-1:0]   in_d_data;
    logic [OUTST_W-1:0]  outstanding;
    logic                idle;
    logic                err_underflow;

    int vectors = 0;
    int miscompares = 0;
    int a_fires = 0;
    int base;

    tl_a_t a_exp[$];
    tl_d_t d_exp[$];
    tl_a_t mon_a_got;
    tl_a_t mon_a_exp;
    tl_d_t mon_d_got;
    tl_d_t mon_d_exp;

    always #5 clock = ~clock;

    tl_mem_bridge #(.MAX_OUTSTANDING(8), .RSP_DEPTH(4)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_a_valid    (in_a_valid),
        .in_a_ready    (in_a_ready),
        .in_a_opcode   (in_a_opcode),
        .in_a_size     (in_a_size),
        .in_a_source   (in_a_source),
        .in_a_address  (in_a_address),
        .in_a_mask     (in_a_mask),
        .in_a_data     (in_a_data),
        .out_a_valid   (out_a_valid),
        .out_a_ready   (out_a_ready),
        .out_a_opcode  (out_a_opcode),
        .out_a_size    (out_a_size),
        .out_a_source  (out_a_source),
        .out_a_address (out_a_address),
        .out_a_mask    (out_a_mask),
        .out_a_data    (out_a_data),
        .out_d_valid   (out_d_valid),
        .out_d_ready   (out_d_ready),
        .out_d_opcode  (out_d_opcode),
        .out_d_size    (out_d_size),
        .out_d_source  (out_d_source),
        .out_d_data    (out_d_data),
        .in_d_valid    (in_d_valid),
        .in_d_ready    (in_d_ready),
        .in_d_opcode   (in_d_opcode),
        .in_d_size     (in_d_size),
        .in_d_source   (in_d_source),
        .in_d_data     (in_d_data),
        .outstanding   (outstanding),
        .idle          (idle),
        .err_underflow (err_underflow)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send_a(input logic [2:0] op, input logic [31:0] addr, input logic [14:0] src,
                          input logic [127:0] data);
        tl_a_t e;
        int n;
        e = '{opcode: op, size: 4'd4, source: src, address: addr, mask: 16'hffff, data: data};
        in_a_valid = 1'b1;
        in_a_opcode = op; in_a_size = 4'd4; in_a_source = src;
        in_a_address = addr; in_a_mask = 16'hffff; in_a_data = data;
        n = 0;
        @(negedge clock);
        while (!in_a_ready && n < 100) begin
            n++;
            @(negedge clock);
        end
        if (!in_a_ready) begin
            vectors++; miscompares++;
            $display("FAIL send_a_timeout: in_a_ready stuck at 0, required 1");
        end else begin
            a_exp.push_back(e);
        end
        @(posedge clock);
        #1 in_a_valid = 1'b0;
    endtask

    task automatic send_d(input logic [2:0] op, input logic [14:0] src, input logic [127:0] data);
        tl_d_t e;
        int n;
        e = '{opcode: op, size: 4'd4, source: src, data: data};
        out_d_valid = 1'b1;
        out_d_opcode = op; out_d_size = 4'd4; out_d_source = src; out_d_data = data;
        n = 0;
        @(negedge clock);
        while (!out_d_ready && n < 100) begin
            n++;
            @(negedge clock);
        end
        if (!out_d_ready) begin
            vectors++; miscompares++;
            $display("FAIL send_d_timeout: out_d_ready stuck at 0, required 1");
        end else begin
            d_exp.push_back(e);
        end
        @(posedge clock);
        #1 out_d_valid = 1'b0;
    endtask

    // Monitors: a beat that fires at the coming edge must match the queue head
    always @(negedge clock) begin
        if (reset_n && out_a_valid && out_a_ready) begin
            a_fires++;
            mon_a_got = '{opcode: out_a_opcode, size: out_a_size, source: out_a_source,
                          address: out_a_address, mask: out_a_mask, data: out_a_data};
            vectors++;
            if (a_exp.size() == 0) begin
                miscompares++;
                $display("FAIL a_unexpected: got %h expected no beat", mon_a_got);
            end else begin
                mon_a_exp = a_exp.pop_front();
                if (mon_a_got !== mon_a_exp) begin
                    miscompares++;
                    $display("FAIL a_payload: got %h expected %h", mon_a_got, mon_a_exp);
                end
            end
        end
        if (reset_n && in_d_valid && in_d_ready) begin
            mon_d_got = '{opcode: in_d_opcode, size: in_d_size, source: in_d_source, data: in_d_data};
            vectors++;
            if (d_exp.size() == 0) begin
                miscompares++;
                $display("FAIL d_unexpected: got %h expected no beat", mon_d_got);
            end else begin
                mon_d_exp = d_exp.pop_front();
                if (mon_d_got !== mon_d_exp) begin
                    miscompares++;
                    $display("FAIL d_payload: got %h expected %h", mon_d_got, mon_d_exp);
                end
            end
        end
    end

    initial begin
        // Reset values
        repeat (2) @(negedge clock);
        check("rst_in_a_ready", in_a_ready, 0);
        check("rst_out_d_ready", out_d_ready, 0);
        check("rst_out_a_valid", out_a_valid, 0);
        check("rst_in_d_valid", in_d_valid, 0);
        check("rst_idle", idle, 1);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err_underflow, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("rel_in_a_ready", in_a_ready, 1);
        check("rel_out_d_ready", out_d_ready, 1);
        step();

        // Single Get round trip
        send_a(TL_GET, 32'h8000_0010, 15'd5, 128'h0);
        @(negedge clock);
        check("get_out_a_valid", out_a_valid, 1);
        check("get_outstanding_pre", outstanding, 0);
        @(negedge clock);
        check("get_outstanding", outstanding, 1);
        check("get_out_a_valid_drop", out_a_valid, 0);
        step();
        send_d(TL_ACCESS_ACK_DATA, 15'd5, 128'hdead_beef_0123_4567_89ab_cdef_5555_aaaa);
        @(negedge clock);
        check("ack_in_d_valid", in_d_valid, 1);
        check("ack_outstanding", outstanding, 0);
        @(negedge clock);
        check("ack_idle", idle, 1);
        step();

        // Outstanding cap: 10 Gets, D held off
        base = a_fires;
        for (int i = 0; i < 10; i++) begin
            send_a(TL_GET, 32'h1000_0000 + 32'(i * 16), 15'(i), 128'h0);
        end
        repeat (3) step();
        @(negedge clock);
        check("cap_fires", 32'(a_fires - base), 8);
        check("cap_outstanding", outstanding, 8);
        check("cap_out_a_valid", out_a_valid, 0);
        check("cap_in_a_ready", in_a_ready, 0);
        step();
        send_d(TL_ACCESS_ACK_DATA, 15'd0, 128'h1111);
        repeat (3) step();
        @(negedge clock);
        check("cap_ninth_fire", 32'(a_fires - base), 9);
        check("cap_outstanding_refill", outstanding, 8);
        step();
        for (int i = 1; i < 10; i++) begin
            send_d(TL_ACCESS_ACK_DATA, 15'(i), 128'(i) << 64);
        end
        repeat (3) step();
        @(negedge clock);
        check("cap_drained", outstanding, 0);
        check("cap_all_fires", 32'(a_fires - base), 10);
        step();

        // D FIFO fills while the core stalls; the 5th beat waits on the bus
        for (int i = 0; i < 5; i++) begin
            send_a(TL_GET, 32'h2000_0000 + 32'(i * 4), 15'(20 + i), 128'h0);
        end
        repeat (3) step();
        in_d_ready = 1'b0;
        send_d(TL_ACCESS_ACK_DATA, 15'd20, 128'ha0);
        send_d(TL_ACCESS_ACK, 15'd21, 128'ha1);
        send_d(TL_ACCESS_ACK_DATA, 15'd22, 128'ha2);
        send_d(TL_ACCESS_ACK, 15'd23, 128'ha3);
        @(negedge clock);
        check("dfull_out_d_ready", out_d_ready, 0);
        check("dfull_in_d_valid", in_d_valid, 1);
        step();
        fork
            send_d(TL_ACCESS_ACK_DATA, 15'd24, 128'ha4);
            begin
                repeat (5) @(negedge clock);
                check("dfull_held_ready", out_d_ready, 0);
                check("dfull_outstanding", outstanding, 1);
                @(posedge clock);
                #1 in_d_ready = 1'b1;
            end
        join
        repeat (8) step();
        @(negedge clock);
        check("dfull_outstanding_end", outstanding, 0);
        check("dfull_queue_empty", 32'(d_exp.size()), 0);
        step();

        // Simultaneous out_a and out_d fire with outstanding 3
        for (int i = 0; i < 3; i++) begin
            send_a(TL_PUT_FULL, 32'h3000_0000 + 32'(i * 16), 15'(30 + i), 128'(i + 7));
        end
        repeat (3) step();
        out_a_ready = 1'b0;
        send_a(TL_PUT_PARTIAL, 32'h3000_0100, 15'd33, 128'h77);
        out_a_ready = 1'b1;
        out_d_valid = 1'b1;
        out_d_opcode = TL_ACCESS_ACK; out_d_size = 4'd4; out_d_source = 15'd30; out_d_data = '0;
        d_exp.push_back('{opcode: TL_ACCESS_ACK, size: 4'd4, source: 15'd30, data: 128'h0});
        @(negedge clock);
        check("both_outstanding_pre", outstanding, 3);
        check("both_out_a_valid", out_a_valid, 1);
        check("both_out_d_ready", out_d_ready, 1);
        @(posedge clock);
        #1 out_d_valid = 1'b0;
        @(negedge clock);
        check("both_outstanding", outstanding, 3);
        step();
        for (int i = 1; i < 4; i++) begin
            send_d(TL_ACCESS_ACK, 15'(30 + i), 128'h0);
        end
        repeat (2) step();

        // Underflow: D beat with nothing in flight
        send_d(TL_ACCESS_ACK_DATA, 15'd99, 128'hbad);
        repeat (3) step();
        @(negedge clock);
        check("uf_err", err_underflow, 1);
        check("uf_outstanding", outstanding, 0);
        check("uf_forwarded", 32'(d_exp.size()), 0);
        step();

        // Reset with 2 A and 3 D entries buffered
        out_a_ready = 1'b0;
        send_a(TL_GET, 32'h4000_0000, 15'd40, 128'h0);
        send_a(TL_GET, 32'h4000_0040, 15'd41, 128'h0);
        in_d_ready = 1'b0;
        send_d(TL_ACCESS_ACK_DATA, 15'd50, 128'hd0);
        send_d(TL_ACCESS_ACK_DATA, 15'd51, 128'hd1);
        send_d(TL_ACCESS_ACK_DATA, 15'd52, 128'hd2);
        @(negedge clock);
        check("prerst_idle", idle, 0);
        check("prerst_in_a_ready", in_a_ready, 0);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_in_a_ready", in_a_ready, 0);
        check("mid_rst_out_d_ready", out_d_ready, 0);
        check("mid_rst_out_a_valid", out_a_valid, 0);
        check("mid_rst_in_d_valid", in_d_valid, 0);
        check("mid_rst_idle", idle, 1);
        check("mid_rst_outstanding", outstanding, 0);
        check("mid_rst_err", err_underflow, 0);
        a_exp.delete();
        d_exp.delete();
        out_a_ready = 1'b1;
        in_d_ready = 1'b1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_in_a_ready", in_a_ready, 1);
        check("post_rst_out_d_ready", out_d_ready, 1);
        repeat (10) @(negedge clock);
        check("post_rst_out_a_valid", out_a_valid, 0);
        check("post_rst_in_d_valid", in_d_valid, 0);
        check("post_rst_idle", idle, 1);
        check("post_rst_a_queue", 32'(a_exp.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tl_mem_bridge.md
TL_MEM_BRIDGE -- requirements
Module: tl_mem_bridge

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 8: cap on in-flight A-channel requests, range 1..64.
REQ-002 SHALL have parameter RSP_DEPTH, default 4: D-channel response FIFO depth, power of two, range 2..16.
REQ-003 SHALL have ports: clock  input  1  single clock for all state.
REQ-004 SHALL have ports: reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: in_a_valid/in_a_ready  input/output  1/1  core-side A handshake.
REQ-006 SHALL have ports: in_a_opcode, size, source, address, mask, data  input  3, 4, 15, 32, 16, 128  core-side A payload.
REQ-007 SHALL have ports: out_a_valid/out_a_ready  output/input  1/1  bus-side A handshake.
REQ-008 SHALL have ports: out_a_opcode, size, source, address, mask, data  output  3, 4, 15, 32, 16, 128  bus-side A payload.
REQ-009 SHALL have ports: out_d_valid/out_d_ready  input/output  1/1  bus-side D handshake.
REQ-010 SHALL have ports: out_d_opcode, size, source, data  input  3, 4, 15, 128  bus-side D payload.
REQ-011 SHALL have ports: in_d_valid/in_d_ready  output/input  1/1  core-side D handshake.
REQ-012 SHALL have ports: in_d_opcode, size, source, data  output  3, 4, 15, 128  core-side D payload.
REQ-013 SHALL have ports: outstanding  output  7  current in-flight count.
REQ-014 SHALL have ports: idle  output  1  no in-flight requests and both buffers empty.
REQ-015 SHALL have ports: err_underflow  output  1  sticky flag, D beat with no request outstanding.

Function
REQ-016 A path SHALL be a 2-entry FIFO; in_a_ready = occupancy<2, registered, with no combinational path from out_a_ready.
REQ-017 A request accepted at edge N SHALL present on out_a_* from cycle N+1; payload SHALL pass bit-exact, order preserved.
REQ-018 out_a_valid SHALL assert only when the A FIFO is non-empty and outstanding<MAX_OUTSTANDING.
REQ-019 outstanding SHALL: +1 on out_a fire, -1 on out_d fire, stay unchanged when both fire in one cycle; it SHALL never exceed MAX_OUTSTANDING.
REQ-020 An out_d fire with outstanding==0 and no simultaneous out_a fire SHALL set err_underflow; outstanding SHALL stay 0.
REQ-021 D path SHALL be a RSP_DEPTH FIFO; out_d_ready = FIFO not full, registered, with no combinational path from in_d_ready.
REQ-022 in_d_* SHALL present the FIFO head one cycle after the beat is captured; every D beat, including AccessAck, SHALL be forwarded unchanged and in order.
REQ-023 Push to a full FIFO SHALL be impossible; a simultaneous push and pop on a non-full FIFO SHALL keep occupancy unchanged.
REQ-024 idle SHALL be combinational: outstanding==0 and both FIFOs empty.
REQ-025 A and D paths SHALL be independent; stalling either SHALL not block the other, except through the REQ-018 gate.

Reset
REQ-026 Asserting reset_n low SHALL immediately clear both FIFOs, outstanding and err_underflow.
REQ-027 During reset: in_a_ready=0, out_d_ready=0, out_a_valid=0, in_d_valid=0, idle=1.
REQ-028 After deassertion, readies SHALL rise on the first clock edge; reset mid-transfer SHALL discard buffered beats without emitting partial state.

Structure
REQ-029 Opcode constants (Get=4, PutFull=0, PutPartial=1, AccessAck=0, AccessAckData=1) and the A/D payload struct typedefs SHALL reside in a shared package, tl_pkg.
REQ-030 A single parameterised sub-module, tl_fifo (width, depth), SHALL implement both the A and D buffers.

Verification
REQ-031 Single Get at address 0x80000010, source 5 -> out_a_valid on the next cycle with identical payload; outstanding=1; an AccessAckData on D returns via in_d one cycle later; outstanding=0; idle=1.
REQ-032 MAX_OUTSTANDING=8, 10 Gets, D held off -> exactly 8 out_a fires; out_a_valid=0 while outstanding=8; A FIFO full, in_a_ready=0; releasing one D beat -> the 9th Get issues.
REQ-033 in_d_ready=0, 4 D beats delivered -> FIFO full, out_d_ready=0 from the following cycle; the 5th beat is held on the bus, not lost.
REQ-034 out_a fire and out_d fire in the same cycle with outstanding=3 -> outstanding stays 3.
REQ-035 D beat with outstanding=0 -> err_underflow=1 and held; outstanding=0; the beat still forwards.
REQ-036 reset_n pulsed low with 2 A and 3 D entries buffered -> all outputs at reset values within the same cycle; no stale beat appears after release.
